// File: rtl/decode_skid_stage_pkg.sv
// ----------------------------------------------------------------------------
// decode_skid_stage_pkg
//   Shared definitions for the instruction decode stage:
//     - field position constants of the fixed 32-bit instruction layout
//     - opcode / register index widths
//     - the list of legal opcodes (used when DECODE_ILLEGAL_CHECK_EN is set)
//     - decoded_instr_t, the payload carried through the skid buffer
//     - slice_instr(), which splits an instruction word into its fields
// ----------------------------------------------------------------------------
package decode_skid_stage_pkg;

   localparam int INSTR_W_DEF  = 32;
   localparam int PC_W_DEF     = 32;
   localparam int IMM_W_DEF    = 15;

   localparam int OPCODE_W     = 6;
   localparam int REG_W        = 5;

   localparam int OP_MSB       = 31;
   localparam int OP_LSB       = 26;
   localparam int RD_MSB       = 25;
   localparam int RD_LSB       = 21;
   localparam int RS_MSB       = 20;
   localparam int RS_LSB       = 16;
   localparam int IMM_SIGN_BIT = 15;
   localparam int IMM_MSB      = 14;

   // Opcodes the execute stage understands; anything else is flagged illegal.
   localparam int NUM_LEGAL = 16;
   localparam logic [OPCODE_W-1:0] LEGAL_OPCODES [NUM_LEGAL] = '{
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
      6'h0A, 6'h0C, 6'h0D, 6'h10, 6'h11, 6'h20, 6'h23, 6'h2B
   };

   typedef struct packed {
      logic [PC_W_DEF-1:0]  pc;
      logic [OPCODE_W-1:0]  opcode;
      logic [REG_W-1:0]     rd;
      logic [REG_W-1:0]     rs;
      logic                 imm_sign;
      logic [IMM_W_DEF-1:0] imm;
      logic                 illegal;
   } decoded_instr_t;

   // Field split only; the illegal flag is filled in by the caller.
   function automatic decoded_instr_t slice_instr(
      input logic [INSTR_W_DEF-1:0] instr,
      input logic [PC_W_DEF-1:0]    pc
   );
      decoded_instr_t d;
      d.pc       = pc;
      d.opcode   = instr[OP_MSB:OP_LSB];
      d.rd       = instr[RD_MSB:RD_LSB];
      d.rs       = instr[RS_MSB:RS_LSB];
      d.imm_sign = instr[IMM_SIGN_BIT];
      d.imm      = instr[IMM_MSB:0];
      d.illegal  = 1'b0;
      return d;
   endfunction

endpackage

// File: rtl/decode_skid_stage_skid.sv
// ----------------------------------------------------------------------------
// skid_buffer_2
//   Generic 2-entry valid/ready skid register. A main register drives the
//   output; a skid register catches the one word that arrives while the main
//   register is full and not draining. in_ready is a function of registered
//   state (and rst) only, so there is no combinational path from out_ready
//   to in_ready. Flush empties both entries; rst empties and zeroes them.
//
//   Ports:
//     clk        clock, rising-edge
//     rst        synchronous active-high reset
//     flush      discard held and incoming words
//     in_valid   upstream word valid
//     in_ready   buffer can accept (skid entry free, not in reset)
//     in_data    upstream word, W bits
//     out_valid  main entry holds a word
//     out_ready  downstream accepts
//     out_data   main entry contents, W bits
// ----------------------------------------------------------------------------
module skid_buffer_2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         main_valid_reg, main_valid_next;
   logic         skid_valid_reg, skid_valid_next;
   logic [W-1:0] main_data_reg,  main_data_next;
   logic [W-1:0] skid_data_reg,  skid_data_next;

   logic accept;
   logic drain;

   assign in_ready = !skid_valid_reg && !rst;
   assign accept   = in_valid && in_ready;
   assign drain    = main_valid_reg && out_ready;

   always_comb begin
      main_valid_next = main_valid_reg;
      skid_valid_next = skid_valid_reg;
      main_data_next  = main_data_reg;
      skid_data_next  = skid_data_reg;

      if (flush) begin
         // Data registers keep their old contents; only the valids drop.
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else begin
         if (!main_valid_reg || drain) begin
            // Main is free this cycle: the skid entry is older than any new
            // input, so it always wins. Input and skid are never both live
            // because in_ready is low while skid is occupied.
            if (skid_valid_reg) begin
               main_data_next  = skid_data_reg;
               main_valid_next = 1'b1;
               skid_valid_next = 1'b0;
            end else if (accept) begin
               main_data_next  = in_data;
               main_valid_next = 1'b1;
            end else begin
               main_valid_next = 1'b0;
            end
         end else if (accept) begin
            // Main is stalled: park the new word in the skid entry.
            skid_data_next  = in_data;
            skid_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         main_data_reg  <= '0;
         skid_data_reg  <= '0;
      end else begin
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
         main_data_reg  <= main_data_next;
         skid_data_reg  <= skid_data_next;
      end
   end

   // Gated with rst so no output transfer can complete in a reset cycle.
   assign out_valid = main_valid_reg && !rst;
   assign out_data  = main_data_reg;

endmodule

// File: rtl/decode_skid_stage.sv
// ----------------------------------------------------------------------------
// decode_skid_stage
//   Registered instruction-decode stage between fetch and the constant unit /
//   ALU. Instructions arrive over valid/ready, are split into fields and held
//   in a 2-entry skid buffer so the stage sustains one instruction per cycle
//   under backpressure. flush discards everything in flight.
//
//   Build option:
//     DECODE_ILLEGAL_CHECK_EN  defined  : out_illegal flags opcodes outside
//                                         the package legal list
//                              undefined: out_illegal is constant 0
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        fetch handshake
//     in_instr, in_pc          instruction word and its address
//     flush                    discard held and incoming instructions
//     out_valid/out_ready      downstream handshake
//     out_pc                   pc of presented instruction
//     out_opcode,out_rd,out_rs instr[31:26], [25:21], [20:16]
//     out_imm_sign             instr[15]: 1 = sign-extend, 0 = zero-extend
//     out_imm                  instr[14:0]
//     out_illegal              opcode not in legal list (see build option)
// ----------------------------------------------------------------------------
module decode_skid_stage #(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32,
   parameter int IMM_W   = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [5:0]         out_opcode,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_rs,
   output logic               out_imm_sign,
   output logic [IMM_W-1:0]   out_imm,
   output logic               out_illegal
);

   import decode_skid_stage_pkg::*;

   localparam int PAYLOAD_W = $bits(decoded_instr_t);

   decoded_instr_t         in_dec;
   decoded_instr_t         out_dec;
   logic [PAYLOAD_W-1:0]   out_bits;
   logic                   illegal_flag;

`ifdef DECODE_ILLEGAL_CHECK_EN
   // One comparator per legal opcode; illegal when none of them hit.
   logic [NUM_LEGAL-1:0] legal_hits;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEGAL; gi++) begin : g_legal
         assign legal_hits[gi] = (in_instr[OP_MSB:OP_LSB] == LEGAL_OPCODES[gi]);
      end
   endgenerate

   assign illegal_flag = ~|legal_hits;
`else
   assign illegal_flag = 1'b0;
`endif

   // Decode happens before the buffer so the stored payload is already split;
   // both entries then carry identical, ready-to-present fields.
   always_comb begin
      in_dec         = slice_instr(in_instr, in_pc);
      in_dec.illegal = illegal_flag;
   end

   skid_buffer_2 #(
      .W (PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_dec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_bits)
   );

   assign out_dec      = decoded_instr_t'(out_bits);
   assign out_pc       = out_dec.pc;
   assign out_opcode   = out_dec.opcode;
   assign out_rd       = out_dec.rd;
   assign out_rs       = out_dec.rs;
   assign out_imm_sign = out_dec.imm_sign;
   assign out_imm      = out_dec.imm;
   assign out_illegal  = out_dec.illegal;

endmodule

// File: tb/tb_decode_skid_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_skid_stage
//   Directed self-checking bench for decode_skid_stage. Inputs change 1 ns
//   after the rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_decode_skid_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs;
   logic        out_imm_sign;
   logic [14:0] out_imm;
   logic        out_illegal;

   int n_compared;
   int n_mismatched;

`ifdef DECODE_ILLEGAL_CHECK_EN
   localparam logic ILL_EN = 1'b1;
`else
   localparam logic ILL_EN = 1'b0;
`endif

   decode_skid_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_opcode   (out_opcode),
      .out_rd       (out_rd),
      .out_rs       (out_rs),
      .out_imm_sign (out_imm_sign),
      .out_imm      (out_imm),
      .out_illegal  (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One line per completed output transaction.
   always @(negedge clk) begin
      if (out_valid && out_ready)
         $display("txn out pc=0x%08h op=0x%02h rd=%0d rs=%0d s=%0d imm=0x%04h ill=%0d",
                  out_pc, out_opcode, out_rd, out_rs, out_imm_sign, out_imm, out_illegal);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      in_valid = v;
      in_instr = instr;
      in_pc    = pc;
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic sg,
                                      input logic [14:0] imm);
      return {op, rd, rs, sg, imm};
   endfunction

   task automatic chk_out(input string tag, input logic [31:0] pc, input logic [5:0] op,
                          input logic [4:0] rd, input logic [4:0] rs, input logic sg,
                          input logic [14:0] imm);
      check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_pc"}, 64'(out_pc), 64'(pc));
      check_eq({tag, "_op"}, 64'(out_opcode), 64'(op));
      check_eq({tag, "_rd"}, 64'(out_rd), 64'(rd));
      check_eq({tag, "_rs"}, 64'(out_rs), 64'(rs));
      check_eq({tag, "_sign"}, 64'(out_imm_sign), 64'(sg));
      check_eq({tag, "_imm"}, 64'(out_imm), 64'(imm));
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);

      // ---------------- reset state ----------------
      tick();
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_pc", 64'(out_pc), 64'd0);
      check_eq("rst_out_op", 64'(out_opcode), 64'd0);
      check_eq("rst_out_illegal", 64'(out_illegal), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

      // ---------------- single instruction ----------------
      out_ready = 1'b1;
      drive(1'b1, 32'h0C22_8005, 32'h100);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk_out("single", 32'h100, 6'h03, 5'd1, 5'd2, 1'b1, 15'h0005);
      check_eq("single_illegal", 64'(out_illegal), 64'd0);
      tick();
      check_eq("single_drained", 64'(out_valid), 64'd0);

      // ---------------- back-to-back 8 ----------------
      for (int i = 0; i < 8; i++) begin
         check_eq("b2b_in_ready", 64'(in_ready), 64'd1);
         drive(1'b1, mk(6'(i + 8), 5'(i), 5'(31 - i), i[0], 15'(i * 100)), 32'h200 + 32'(4 * i));
         tick();
         chk_out("b2b", 32'h200 + 32'(4 * i), 6'(i + 8), 5'(i), 5'(31 - i), i[0], 15'(i * 100));
      end
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check_eq("b2b_empty", 64'(out_valid), 64'd0);

      // ---------------- backpressure: 3 instrs, out_ready=0 ----------------
      out_ready = 1'b0;
      drive(1'b1, mk(6'h01, 5'd3, 5'd4, 1'b0, 15'h0A0A), 32'h300);
      tick();
      chk_out("bp_a", 32'h300, 6'h01, 5'd3, 5'd4, 1'b0, 15'h0A0A);
      check_eq("bp_ready_after_a", 64'(in_ready), 64'd1);
      drive(1'b1, mk(6'h02, 5'd5, 5'd6, 1'b1, 15'h7FFF), 32'h304);
      tick();
      check_eq("bp_ready_full", 64'(in_ready), 64'd0);
      chk_out("bp_a_hold", 32'h300, 6'h01, 5'd3, 5'd4, 1'b0, 15'h0A0A);
      drive(1'b1, mk(6'h04, 5'd7, 5'd8, 1'b0, 15'h1234), 32'h308);
      tick();
      check_eq("bp_ready_still_full", 64'(in_ready), 64'd0);
      chk_out("bp_a_hold2", 32'h300, 6'h01, 5'd3, 5'd4, 1'b0, 15'h0A0A);
      out_ready = 1'b1;
      tick();
      chk_out("bp_b", 32'h304, 6'h02, 5'd5, 5'd6, 1'b1, 15'h7FFF);
      check_eq("bp_ready_back", 64'(in_ready), 64'd1);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk_out("bp_c", 32'h308, 6'h04, 5'd7, 5'd8, 1'b0, 15'h1234);
      tick();
      check_eq("bp_empty", 64'(out_valid), 64'd0);

      // ---------------- flush with skid full and in_valid ----------------
      out_ready = 1'b0;
      drive(1'b1, mk(6'h05, 5'd9, 5'd10, 1'b0, 15'h0001), 32'h400);
      tick();
      drive(1'b1, mk(6'h08, 5'd11, 5'd12, 1'b0, 15'h0002), 32'h404);
      tick();
      check_eq("fl_full_ready", 64'(in_ready), 64'd0);
      drive(1'b1, mk(6'h09, 5'd13, 5'd14, 1'b0, 15'h0003), 32'h408);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("fl_out_valid", 64'(out_valid), 64'd0);
      check_eq("fl_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      drive(1'b1, mk(6'h0A, 5'd15, 5'd16, 1'b1, 15'h0004), 32'h500);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk_out("fl_next", 32'h500, 6'h0A, 5'd15, 5'd16, 1'b1, 15'h0004);
      tick();
      check_eq("fl_next_drained", 64'(out_valid), 64'd0);

      // ---------------- flush drops a same-cycle handshake ----------------
      out_ready = 1'b0;
      drive(1'b1, mk(6'h0C, 5'd17, 5'd18, 1'b0, 15'h0005), 32'h600);
      tick();
      drive(1'b1, mk(6'h0D, 5'd19, 5'd20, 1'b0, 15'h0006), 32'h604);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check_eq("fl2_out_valid", 64'(out_valid), 64'd0);
      tick();
      check_eq("fl2_still_empty", 64'(out_valid), 64'd0);

      // ---------------- rst mid-stream ----------------
      drive(1'b1, mk(6'h10, 5'd21, 5'd22, 1'b1, 15'h4321), 32'h700);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk_out("rst_pre", 32'h700, 6'h10, 5'd21, 5'd22, 1'b1, 15'h4321);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_in_ready", 64'(in_ready), 64'd0);
      tick();
      check_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_mid_pc", 64'(out_pc), 64'd0);
      check_eq("rst_mid_op", 64'(out_opcode), 64'd0);
      check_eq("rst_mid_imm", 64'(out_imm), 64'd0);
      check_eq("rst_mid_in_ready2", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rst_mid_after_ready", 64'(in_ready), 64'd1);

      // ---------------- illegal opcode flag ----------------
      out_ready = 1'b1;
      drive(1'b1, mk(6'h3F, 5'd1, 5'd1, 1'b0, 15'h0), 32'h800);
      tick();
      chk_out("ill_3f", 32'h800, 6'h3F, 5'd1, 5'd1, 1'b0, 15'h0);
      check_eq("ill_3f_flag", 64'(out_illegal), 64'(ILL_EN));
      drive(1'b1, mk(6'h03, 5'd2, 5'd2, 1'b0, 15'h1), 32'h804);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk_out("ill_03", 32'h804, 6'h03, 5'd2, 5'd2, 1'b0, 15'h1);
      check_eq("ill_03_flag", 64'(out_illegal), 64'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000 ns");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decode_skid_stage.md
Name: decode_skid_stage

Overview:
- Registered instruction-decode stage between instruction fetch and the constant/immediate extension unit and ALU.
- Accepts fetched instruction words over a valid/ready handshake and splits them into fields: opcode, rd, rs, 15-bit immediate and immediate sign-select bit.
- Presents the fields, registered, to downstream consumers.
- A 2-entry skid buffer sustains one instruction per cycle under backpressure; flush discards in-flight instructions on branch redirect.

Parameters:
- INSTR_W, 32, instruction word width; fixed field layout requires 32.
- PC_W, 32, program counter width carried alongside the instruction.
- IMM_W, 15, immediate field width delivered to the constant unit.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready
- in_instr  input  INSTR_W  instruction word
- in_pc  input  PC_W  address of in_instr
- flush  input  1  discard all held and incoming instructions
- out_valid  output  1  decoded instruction available
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready
- out_pc  output  PC_W  pc of presented instruction
- out_opcode  output  6  instr[31:26]
- out_rd  output  5  instr[25:21]
- out_rs  output  5  instr[20:16]
- out_imm_sign  output  1  instr[15]; 1 = sign-extend, 0 = zero-extend; feeds constant unit select
- out_imm  output  IMM_W  instr[14:0]
- out_illegal  output  1  opcode not in legal set (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values, applied at the first edge with rst=1: out_valid=0, skid_valid=0, all data fields 0, out_illegal=0.
  - in_ready=0 while rst=1; in_ready=1 on the first cycle after rst falls.
- Storage: a main register (drives outputs) and a skid register, each with a valid bit. Decode is a slicing of the stored instruction word.
- in_ready = !skid_valid && !rst. This is a registered-state function only; no combinational path from out_ready.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 when the stage was empty.
- Main register update priority:
  1. flush
  2. main empty or being drained → load from skid if skid_valid, else from input if accepted
  3. hold.
- Skid register:
  - Loads the input when an input is accepted while main is valid and not drained.
  - Clears when its entry moves to main.
- Simultaneous accept and drain with skid empty: input goes directly to main; skid stays empty. Full throughput, no bubble.
- Full (skid_valid=1): in_ready=0. Draining main moves skid→main; in_ready returns to 1 the following cycle.
- Empty: out_valid=0. Output field values are don't-care but hold their last value. Bench must not check fields while out_valid=0.
- Order preserved: outputs appear strictly in acceptance order; no drop or duplicate without flush.
- flush=1 at an edge:
  - main_valid and skid_valid both become 0.
  - Any input handshaking in the same cycle is dropped.
  - out_valid=0 next cycle; in_ready=1 next cycle.
  - flush has priority over all other events.
- rst asserted mid-stream: same effect as flush plus data zeroing. No output transfer completes in the reset cycle.
- out_valid, once asserted, stays asserted with stable fields until handshake, flush or rst.

Optional Feature:
- Macro DECODE_ILLEGAL_CHECK_EN.
- Defined: out_illegal=1 when the presented opcode is not in the package's legal opcode list. The flag is registered alongside the fields and valid only with out_valid.
- Undefined: out_illegal tied to 0; no comparison logic synthesised.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package holds:
  - field position constants (OP_MSB=31, OP_LSB=26, RD_MSB=25, RD_LSB=21, RS_MSB=20, RS_LSB=16, IMM_SIGN_BIT=15, IMM_MSB=14);
  - opcode width 6;
  - the legal opcode constant list;
  - a decoded-instruction struct typedef (pc, opcode, rd, rs, imm_sign, imm, illegal).
- One natural sub-module: skid_buffer_2, a generic 2-entry valid/ready skid register parameterised on payload width. The decode stage instantiates it with the struct as payload.

Test Plan:
- Single instr 0x0C22_8005, pc 0x100, out_ready=1 → next cycle out_opcode=0x03, out_rd=1, out_rs=2, out_imm_sign=1, out_imm=0x0005, out_pc=0x100.
- Back-to-back 8 instrs, out_ready=1 → one output per cycle, in order, in_ready never deasserts.
- out_ready=0 while sending 3 instrs → first two captured (main+skid), in_ready=0 after second; third held by fetch. Releasing out_ready yields all three in order, no duplicates.
- flush with skid full and in_valid=1 → out_valid=0 next cycle, in_ready=1, flushed instrs never appear; next instr after flush emitted normally.
- rst pulse mid-stream with out_valid=1 → out_valid=0, fields 0, in_ready=0 during rst, 1 after.
- With DECODE_ILLEGAL_CHECK_EN: unlisted opcode 0x3F → out_illegal=1; legal opcode → 0. Without the macro → always 0.
